// File: rtl/ps2_key_pkg.sv
// ps2_key_pkg: shared constants and types for the PS/2 key event path.
//   PS2_PREFIX_EXT / PS2_PREFIX_BRK : scan-code prefix bytes (E0 extended, F0 break)
//   ST_*                             : 2-bit sequencer state encoding
//   key_event_t                      : key event record used by downstream consumers
package ps2_key_pkg;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_DECODE = 2'd2;
    localparam logic [1:0] ST_EMIT   = 2'd3;

    localparam int unsigned PS2_CODE_W = 8;

    typedef struct packed {
        logic [PS2_CODE_W-1:0] code;
        logic                  ext;
        logic                  brk;
        logic                  rep;
    } key_event_t;

endpackage

// File: rtl/ps2_prefix_timer.sv
// ps2_prefix_timer: counts cycles a scan-code prefix has been pending.
//   clock, reset : system clock, synchronous active-high reset
//   run          : a prefix is pending and the sequencer is idle
//   clear        : a byte is being popped; restart the count
//   expired      : high in the cycle the count reaches TIMEOUT_CYC-1
module ps2_prefix_timer #(
    parameter int unsigned TIMEOUT_CYC = 1000000,
    parameter int unsigned TIMEOUT_W   = 20
) (
    input  logic clock,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic expired
);

    localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'(TIMEOUT_CYC - 1);

    logic [TIMEOUT_W-1:0] count_q;

    assign expired = run && (count_q == LAST);

    always_ff @(posedge clock) begin
        if (reset || clear || !run || expired) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + TIMEOUT_W'(1);
        end
    end

endmodule

// File: rtl/ps2_key_ctrl.sv
// ps2_key_ctrl: owns the read side of the PS/2 receiver FIFO, folds E0/F0
// prefixes into single key events and tracks held key / press statistics.
//   clock, reset         : system clock, synchronous active-high reset
//   kbd_ready/kbd_data   : receiver FIFO non-empty flag and head byte
//   kbd_overflow         : receiver FIFO overflow flag
//   kbd_nextdata_n       : active-low one-cycle pop strobe
//   evt_valid/evt_ready  : key event handshake
//   evt_code/ext/break/repeat : event payload
//   cur_key, key_held    : currently held key
//   press_count          : non-repeat presses, wraps
//   ovf_sticky           : overflow seen since reset
// Optional: define PS2_KEY_CTRL_TIMEOUT_EN to drop a prefix that waits longer
// than TIMEOUT_CYC cycles for its data byte.
module ps2_key_ctrl
    import ps2_key_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 1000000,
    parameter int unsigned TIMEOUT_W   = 20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       kbd_ready,
    input  logic [7:0] kbd_data,
    input  logic       kbd_overflow,
    output logic       kbd_nextdata_n,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic       evt_ext,
    output logic       evt_break,
    output logic       evt_repeat,
    output logic [7:0] cur_key,
    output logic       key_held,
    output logic [7:0] press_count,
    output logic       ovf_sticky
);

    if ((TIMEOUT_CYC >> TIMEOUT_W) != 0) begin : g_bad_timeout_w
        $error("TIMEOUT_W too narrow for TIMEOUT_CYC");
    end

    logic [1:0] state_q, state_d;
    logic [7:0] byte_q, byte_d;
    logic       ext_f_q, ext_f_d;
    logic       brk_f_q, brk_f_d;
    key_event_t evt_q, evt_d;
    logic [7:0] cur_key_q, cur_key_d;
    logic       key_held_q, key_held_d;
    logic [7:0] press_count_q, press_count_d;
    logic       ovf_q, ovf_d;
    logic       repeat_hit;
    logic       pop;
    logic       timeout_hit;

    // Pop is combinational so the strobe lands in the IDLE cycle that latches the byte.
    assign pop = (state_q == ST_IDLE) && kbd_ready && !reset;

`ifdef PS2_KEY_CTRL_TIMEOUT_EN
    ps2_prefix_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TIMEOUT_W   (TIMEOUT_W)
    ) u_prefix_timer (
        .clock   (clock),
        .reset   (reset),
        .run     ((state_q == ST_IDLE) && (ext_f_q || brk_f_q)),
        .clear   (pop),
        .expired (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        byte_d        = byte_q;
        ext_f_d       = ext_f_q;
        brk_f_d       = brk_f_q;
        evt_d         = evt_q;
        cur_key_d     = cur_key_q;
        key_held_d    = key_held_q;
        press_count_d = press_count_q;
        ovf_d         = ovf_q | kbd_overflow;
        repeat_hit    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (kbd_ready) begin
                    byte_d  = kbd_data;
                    state_d = ST_SETTLE;
                end else if (timeout_hit) begin
                    ext_f_d = 1'b0;
                    brk_f_d = 1'b0;
                end
            end
            ST_SETTLE: begin
                // Dead cycle: lets kbd_ready reflect the pop before the next IDLE.
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (byte_q == PS2_PREFIX_EXT) begin
                    ext_f_d = 1'b1;
                    state_d = ST_IDLE;
                end else if (byte_q == PS2_PREFIX_BRK) begin
                    brk_f_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    repeat_hit = !brk_f_q && key_held_q && (byte_q == cur_key_q);
                    evt_d      = '{code: byte_q, ext: ext_f_q, brk: brk_f_q, rep: repeat_hit};
                    ext_f_d    = 1'b0;
                    brk_f_d    = 1'b0;
                    state_d    = ST_EMIT;
                    if (!brk_f_q && !repeat_hit) begin
                        cur_key_d     = byte_q;
                        key_held_d    = 1'b1;
                        press_count_d = press_count_q + 8'd1;
                    end else if (brk_f_q && (byte_q == cur_key_q)) begin
                        cur_key_d  = 8'h00;
                        key_held_d = 1'b0;
                    end
                end
            end
            ST_EMIT: begin
                if (evt_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            byte_q        <= 8'h00;
            ext_f_q       <= 1'b0;
            brk_f_q       <= 1'b0;
            evt_q         <= '0;
            cur_key_q     <= 8'h00;
            key_held_q    <= 1'b0;
            press_count_q <= 8'h00;
            ovf_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            byte_q        <= byte_d;
            ext_f_q       <= ext_f_d;
            brk_f_q       <= brk_f_d;
            evt_q         <= evt_d;
            cur_key_q     <= cur_key_d;
            key_held_q    <= key_held_d;
            press_count_q <= press_count_d;
            ovf_q         <= ovf_d;
        end
    end

    assign kbd_nextdata_n = !pop;
    assign evt_valid      = (state_q == ST_EMIT);
    assign evt_code       = evt_q.code;
    assign evt_ext        = evt_q.ext;
    assign evt_break      = evt_q.brk;
    assign evt_repeat     = evt_q.rep;
    assign cur_key        = cur_key_q;
    assign key_held       = key_held_q;
    assign press_count    = press_count_q;
    assign ovf_sticky     = ovf_q;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Bench for ps2_key_ctrl: receiver FIFO model, byte-level event reference model,
// table-driven scan sequences, hand-written corner cases and random traffic.
module tb_ps2_key_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       kbd_ready = 1'b0;
    logic [7:0] kbd_data = 8'h00;
    logic       kbd_overflow = 1'b0;
    logic       kbd_nextdata_n;
    logic       evt_valid;
    logic       evt_ready = 1'b0;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_break;
    logic       evt_repeat;
    logic [7:0] cur_key;
    logic       key_held;
    logic [7:0] press_count;
    logic       ovf_sticky;

    always #5 clock = ~clock;

    ps2_key_ctrl #(
        .TIMEOUT_CYC (16),
        .TIMEOUT_W   (20)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .kbd_ready      (kbd_ready),
        .kbd_data       (kbd_data),
        .kbd_overflow   (kbd_overflow),
        .kbd_nextdata_n (kbd_nextdata_n),
        .evt_valid      (evt_valid),
        .evt_ready      (evt_ready),
        .evt_code       (evt_code),
        .evt_ext        (evt_ext),
        .evt_break      (evt_break),
        .evt_repeat     (evt_repeat),
        .cur_key        (cur_key),
        .key_held       (key_held),
        .press_count    (press_count),
        .ovf_sticky     (ovf_sticky)
    );

    typedef struct {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic       rep;
        logic [7:0] count;
        logic [7:0] cur;
        logic       held;
    } exp_evt_t;

    typedef struct {
        logic [39:0] bytes;
        int          n;
        int          nevt;
        logic [7:0]  count;
        logic        held;
        logic [7:0]  cur;
        logic [7:0]  lcode;
        logic        lext;
        logic        lbrk;
        logic        lrep;
    } vec_t;

    exp_evt_t   exp_q[$];
    logic [7:0] fifo[$];
    int         checks = 0;
    int         errors = 0;
    int         n_evt = 0;
    int         pulses = 0;
    logic       pop_prev = 1'b0;

    // Reference model state: what the key stream means, byte by byte.
    logic       m_ext = 1'b0, m_brk = 1'b0, m_held = 1'b0;
    logic [7:0] m_cur = 8'h00, m_count = 8'h00;
    logic [7:0] last_code = 8'h00;
    logic       last_ext = 1'b0, last_brk = 1'b0, last_rep = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_clear();
        m_ext = 1'b0; m_brk = 1'b0; m_held = 1'b0; m_cur = 8'h00; m_count = 8'h00;
        exp_q.delete();
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        logic rep;
        if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            rep = !m_brk && m_held && (b == m_cur);
            if (!m_brk && !rep) begin
                m_cur = b; m_held = 1'b1; m_count = m_count + 8'd1;
            end else if (m_brk && (b == m_cur)) begin
                m_cur = 8'h00; m_held = 1'b0;
            end
            exp_q.push_back('{b, m_ext, m_brk, rep, m_count, m_cur, m_held});
            m_ext = 1'b0; m_brk = 1'b0;
        end
    endfunction

    task automatic drive();
        kbd_ready = (fifo.size() != 0);
        kbd_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
    endtask

    task automatic push(input logic [7:0] b);
        fifo.push_back(b);
        drive();
    endtask

    // One clock: observe at the falling edge, apply the pop just after the rising edge.
    task automatic tick();
        logic     pop_now;
        exp_evt_t e;
        @(negedge clock);
        pop_now = !kbd_nextdata_n;
        if (pop_now) begin
            pulses++;
            check("pop_single_cycle", pop_prev, 0);
            check("pop_needs_ready", kbd_ready, 1);
        end
        if (evt_valid && evt_ready) begin
            n_evt++;
            last_code = evt_code; last_ext = evt_ext; last_brk = evt_break; last_rep = evt_repeat;
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL evt_unexpected: got code %0h, expected no event", evt_code);
            end else begin
                e = exp_q.pop_front();
                check("evt_code", evt_code, e.code);
                check("evt_ext", evt_ext, e.ext);
                check("evt_break", evt_break, e.brk);
                check("evt_repeat", evt_repeat, e.rep);
                check("evt_press_count", press_count, e.count);
                check("evt_cur_key", cur_key, e.cur);
                check("evt_key_held", key_held, e.held);
            end
        end
        pop_prev = pop_now;
        @(posedge clock);
        #1;
        if (pop_now && fifo.size() != 0) model_byte(fifo.pop_front());
        drive();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        evt_ready = 1'b0;
        fifo.delete();
        drive();
        tick();
        tick();
        reset = 1'b0;
        model_clear();
        n_evt = 0; pulses = 0; pop_prev = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_nextdata_n"}, kbd_nextdata_n, 1);
        check({tag, "_evt_valid"}, evt_valid, 0);
        check({tag, "_evt_code"}, evt_code, 0);
        check({tag, "_evt_ext"}, evt_ext, 0);
        check({tag, "_evt_break"}, evt_break, 0);
        check({tag, "_evt_repeat"}, evt_repeat, 0);
        check({tag, "_cur_key"}, cur_key, 0);
        check({tag, "_key_held"}, key_held, 0);
        check({tag, "_press_count"}, press_count, 0);
        check({tag, "_ovf_sticky"}, ovf_sticky, 0);
    endtask

    vec_t       vecs[7];
    logic [7:0] pool[6];

    initial begin
        int   p0;
        logic stable;
        logic exp_brk;

        vecs[0] = '{40'h1CF01C0000, 3, 2, 8'h01, 1'b0, 8'h00, 8'h1C, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{40'h1B1B1BF01B, 5, 4, 8'h01, 1'b0, 8'h00, 8'h1B, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{40'hE075E0F075, 5, 2, 8'h01, 1'b0, 8'h00, 8'h75, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{40'h1C32000000, 2, 2, 8'h02, 1'b1, 8'h32, 8'h32, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{40'h1CF0320000, 3, 2, 8'h01, 1'b1, 8'h1C, 8'h32, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{40'hF0E0700000, 3, 1, 8'h00, 1'b0, 8'h00, 8'h70, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{40'hE0E0710000, 3, 1, 8'h01, 1'b1, 8'h71, 8'h71, 1'b1, 1'b0, 1'b0};
        pool = '{8'hE0, 8'hF0, 8'h1C, 8'h1B, 8'h32, 8'h75};

        // Reset state while reset is still held.
        @(posedge clock);
        #1;
        check_reset_outputs("init");
        do_reset();

        // Table-driven scan sequences.
        for (int v = 0; v < 7; v++) begin
            do_reset();
            for (int i = 0; i < vecs[v].n; i++) push(vecs[v].bytes[39-8*i -: 8]);
            evt_ready = 1'b1;
            repeat (5 * vecs[v].n + 10) tick();
            check("vec_events", n_evt, vecs[v].nevt);
            check("vec_pop_pulses", pulses, vecs[v].n);
            check("vec_press_count", press_count, vecs[v].count);
            check("vec_key_held", key_held, vecs[v].held);
            check("vec_cur_key", cur_key, vecs[v].cur);
            check("vec_last_code", last_code, vecs[v].lcode);
            check("vec_last_ext", last_ext, vecs[v].lext);
            check("vec_last_brk", last_brk, vecs[v].lbrk);
            check("vec_last_rep", last_rep, vecs[v].lrep);
            check("vec_drained", exp_q.size(), 0);
        end

        // Backpressure: event held stable, no pop while stalled.
        do_reset();
        push(8'h1C);
        push(8'h32);
        for (int k = 0; k < 20 && !evt_valid; k++) tick();
        check("bp_valid", evt_valid, 1);
        check("bp_code", evt_code, 8'h1C);
        p0 = pulses;
        stable = 1'b1;
        repeat (20) begin
            tick();
            if (!(evt_valid && evt_code == 8'h1C && !evt_break && !evt_ext && !evt_repeat
                  && kbd_nextdata_n)) stable = 1'b0;
        end
        check("bp_stable", stable, 1);
        check("bp_no_pop", pulses, p0);
        check("bp_fifo_ready", kbd_ready, 1);
        evt_ready = 1'b1;
        tick();
        tick();
        check("bp_pop_after_accept", pulses, p0 + 1);
        repeat (10) tick();
        check("bp_events", n_evt, 2);

        // press_count wrap, overflow sticky, reset during SETTLE.
        do_reset();
        evt_ready = 1'b1;
        for (int i = 0; i < 255; i++) push(i[0] ? 8'h15 : 8'h16);
        for (int k = 0; k < 1200 && (fifo.size() != 0 || exp_q.size() != 0); k++) tick();
        repeat (5) tick();
        check("wrap_count_ff", press_count, 8'hFF);
        push(8'h1C);
        repeat (10) tick();
        check("wrap_count_00", press_count, 8'h00);
        check("wrap_cur_key", cur_key, 8'h1C);
        kbd_overflow = 1'b1;
        tick();
        kbd_overflow = 1'b0;
        repeat (3) tick();
        check("ovf_sticky_set", ovf_sticky, 1);
        push(8'h33);
        p0 = pulses;
        for (int k = 0; k < 10 && pulses == p0; k++) tick();
        check("settle_pop_seen", pulses, p0 + 1);
        check("ovf_sticky_hold", ovf_sticky, 1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_reset_outputs("settle_rst");
        reset = 1'b0;
        model_clear();
        fifo.delete();
        drive();

        // Prefix left waiting for a long time.
        do_reset();
        evt_ready = 1'b1;
        push(8'hF0);
        repeat (20) tick();
`ifdef PS2_KEY_CTRL_TIMEOUT_EN
        m_ext = 1'b0; m_brk = 1'b0;
        exp_brk = 1'b0;
`else
        exp_brk = 1'b1;
`endif
        push(8'h1C);
        repeat (10) tick();
        check("idle_prefix_events", n_evt, 1);
        check("idle_prefix_code", last_code, 8'h1C);
        check("idle_prefix_brk", last_brk, exp_brk);

        // Random traffic against the reference model.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            push(pool[$urandom_range(0, 5)]);
            evt_ready = ($urandom_range(0, 3) != 0);
            repeat ($urandom_range(1, 4)) tick();
        end
        evt_ready = 1'b1;
        for (int k = 0; k < 3000 && (fifo.size() != 0 || exp_q.size() != 0); k++) tick();
        repeat (10) tick();
        check("rand_drained", exp_q.size() + fifo.size(), 0);
        check("rand_press_count", press_count, m_count);
        check("rand_cur_key", cur_key, m_cur);
        check("rand_key_held", key_held, m_held);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ps2_key_ctrl.md
Name: ps2_key_ctrl

Overview:
Sequencer between the ps2_keyboard receiver FIFO and downstream consumers such as the display/ASCII path. It pops raw scan bytes using the nextdata_n handshake and folds the E0 (extended) and F0 (break) prefixes into single key events. It delivers each event over a valid/ready port and maintains press statistics. This replaces ad-hoc polling of raw data with a single owner of the receiver's read side.

Parameters:
TIMEOUT_CYC, 1000000, clock cycles a pending prefix may wait for its next byte (used only with PS2_KEY_CTRL_TIMEOUT_EN)
TIMEOUT_W, 20, counter width; must satisfy 2^TIMEOUT_W > TIMEOUT_CYC

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
kbd_ready  in  1  receiver FIFO non-empty
kbd_data  in  8  receiver FIFO head byte
kbd_overflow  in  1  receiver FIFO overflow flag
kbd_nextdata_n  out  1  active-low pop strobe to receiver
evt_valid  out  1  key event available
evt_ready  in  1  consumer accepts event
evt_code  out  8  scan code with prefixes removed
evt_ext  out  1  event carried E0 prefix
evt_break  out  1  1 = release, 0 = press
evt_repeat  out  1  press of the key already held (typematic)
cur_key  out  8  last pressed, still-held code (00 if none)
key_held  out  1  a key is currently held
press_count  out  8  count of non-repeat presses, wraps FF->00
ovf_sticky  out  1  kbd_overflow was seen since reset

Behaviour:
- Reset values: kbd_nextdata_n=1, evt_valid=0, evt_code=00, evt_ext=0, evt_break=0, evt_repeat=0, cur_key=00, key_held=0, press_count=00, ovf_sticky=0. Prefix flags are cleared and FSM=IDLE.
- FSM IDLE: if kbd_ready, latch kbd_data into byte_r, drive kbd_nextdata_n=0 for exactly one cycle, go to SETTLE.
- SETTLE: kbd_nextdata_n=1; one dead cycle so kbd_ready reflects the pop. Go to DECODE.
- DECODE:
  - byte_r=E0: set ext_f, go to IDLE.
  - byte_r=F0: set brk_f, go to IDLE.
  - Any other byte: load evt_code=byte_r, evt_ext=ext_f, evt_break=brk_f. Set evt_repeat = !brk_f && key_held && byte_r==cur_key. Clear both flags and go to EMIT.
- EMIT: evt_valid=1 with all evt_* fields stable. On evt_valid&&evt_ready, deassert the next cycle and return to IDLE. There is no pop while in EMIT; backpressure is absorbed by the receiver FIFO.
- State updates on the DECODE-to-EMIT transition:
  - Press, not repeat: cur_key=byte_r, key_held=1, press_count+1 (8-bit wrap).
  - Break with byte_r==cur_key: key_held=0, cur_key=00.
  - Break of a different key: no change to cur_key.
  - Repeat: no count change.
- Minimum spacing is 4 cycles per data byte (IDLE, SETTLE, DECODE, EMIT with evt_ready=1) and 3 cycles per prefix byte.
- Duplicate prefixes (E0 E0, F0 F0) are idempotent. The order E0 F0 and F0 E0 are both accepted.
- ovf_sticky is set in any cycle with kbd_overflow=1 and is cleared only by reset. Decoding continues regardless.
- Reset asserted mid-sequence (any state, including while kbd_nextdata_n=0) returns to reset values on the next edge. A pending prefix is discarded.

Optional Feature:
PS2_KEY_CTRL_TIMEOUT_EN
- Defined: a TIMEOUT_W-bit counter runs while in IDLE with ext_f|brk_f set. It is cleared on any pop. When it reaches TIMEOUT_CYC-1, both flags clear, so the next byte decodes as a plain press.
- Undefined: the counter is not built and prefix flags persist indefinitely until a data byte arrives.

Decomposition:
- Package ps2_key_pkg holds:
  - localparams PS2_PREFIX_EXT=8'hE0 and PS2_PREFIX_BRK=8'hF0.
  - The FSM state encoding (IDLE, SETTLE, DECODE, EMIT; 2-bit).
  - A key event struct/field width constant shared with downstream consumers.
- One sub-module is natural: ps2_prefix_timer (the optional timeout counter). It is instantiated only under PS2_KEY_CTRL_TIMEOUT_EN.
- The remainder is a single FSM module.

Test Plan:
- Bytes 1C, F0, 1C with evt_ready=1: expect two events.
  - Event 1: {code=1C, brk=0, ext=0, rep=0}.
  - Event 2: {code=1C, brk=1}.
  - After both: press_count=01, key_held=0, cur_key=00. kbd_nextdata_n pulses low exactly 3 times, one cycle each.
- Bytes 1B, 1B, 1B, F0, 1B: expect 4 events with rep=0,1,1 then break. press_count=01.
- Bytes E0, 75, E0, F0, 75: expect {75, ext=1, brk=0} then {75, ext=1, brk=1}. No events emitted for prefix bytes.
- Hold evt_ready=0 for 20 cycles with a 1C event pending, and kbd_ready=1: evt fields remain stable and kbd_nextdata_n stays 1. Raising evt_ready completes the handshake, then the next pop occurs.
- Preload press_count to FF via 255 distinct presses, then press 1C: press_count=00. A kbd_overflow pulse sets ovf_sticky=1, which holds until reset. Reset asserted during SETTLE returns all outputs to reset values.
- With PS2_KEY_CTRL_TIMEOUT_EN and TIMEOUT_CYC=16: send F0, idle 20 cycles, send 1C. Expect a press event {1C, brk=0}.
